bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Four-master round-robin arbiter for the shared slave bus.
- Grants the bus to one requester at a time.
- Holds the grant until the combined slave acknowledge arrives (the OR of ack0..ack3, produced by the ack-combining stage), the owner drops its request, or a timeout expires.
- Sits directly downstream of the ack combiner and consumes its `ack` output.

Parameters:
- TIMEOUT, 16, number of BUSY cycles without ack before a forced release (legal 2..255).
- CNT_W, 8, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- req0  input  1  request from master 0, active-high, level.
- req1  input  1  request from master 1.
- req2  input  1  request from master 2.
- req3  input  1  request from master 3.
- ack  input  1  combined slave acknowledge, active-high, sampled on clk.
- gnt0  output  1  grant to master 0, registered.
- gnt1  output  1  grant to master 1, registered.
- gnt2  output  1  grant to master 2, registered.
- gnt3  output  1  grant to master 3, registered.
- owner  output  2  index of current or last grantee, registered.
- busy  output  1  high while any grant is asserted.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst low, asynchronous): gnt0..gnt3=0, owner=3, busy=0, timeout=0, counter=0, state=IDLE. owner=3 makes master 0 highest priority after reset. Reset mid-grant drops the grant immediately, without waiting for a clock.
- States: IDLE, BUSY. All outputs are registered.
- IDLE:
  - If any req is high at a rising edge, grant the first requester searching owner+1, owner+2, ... (mod 4).
  - At that edge: set the selected gnt, owner=index, busy=1, counter=0, go to BUSY.
  - Latency: req sampled at edge k gives gnt high after edge k.
  - ack in IDLE is ignored.
- BUSY, evaluated each edge in this priority order:
  1. ack=1: clear gnt, busy=0, go to IDLE.
  2. Owner's req=0 (abandoned): clear gnt, busy=0, go to IDLE.
  3. counter==TIMEOUT-1: clear gnt, busy=0, timeout=1 for exactly one cycle, go to IDLE.
  4. Otherwise: counter+1, hold gnt.
- ack and timeout on the same edge: ack wins, no timeout pulse.
- After any release, IDLE lasts at least one cycle, so back-to-back grants have a one-cycle gap. This gives the ack combiner's inputs time to negate.
- owner keeps its value in IDLE and is the round-robin pointer. Fairness: a continuously requesting master waits at most 3 grants.
- Counter saturates, never wraps. It is cleared on every grant.
- Invariant: at most one gnt high, and busy equals the OR of gnt0..gnt3.
- Requests arriving while BUSY wait, with no loss, until the next IDLE arbitration.

Decomposition:
- Shared package: state enum (IDLE, BUSY), TIMEOUT default constant, master-count constant (4).
- Active-high/active-low level constants come from the existing shared switch header.
- One combinational sub-module, rr_pick. Inputs: 4-bit request vector, 2-bit pointer. Outputs: 2-bit winner, valid. The arbiter registers its result.

Test Plan:
- Single requester: reset release, req2=1 at cycle 2 -> gnt2=1, owner=2, busy=1 after next edge; ack pulse one cycle later -> gnt2=0, busy=0 after that edge.
- Round-robin: req0..req3 held high, ack pulsed once per grant -> grant order 0,1,2,3,0, with one idle cycle between grants.
- Timeout: req1=1, ack held low -> gnt1 held exactly 16 cycles, then timeout=1 for one cycle, gnt1=0; next grant to req1 after the idle cycle if still requesting.
- Abandon: req3 granted, req3 drops at cycle 4 of BUSY -> gnt3=0 after that edge, no timeout pulse, owner stays 3.
- Ack/timeout collision: ack asserted on the 16th BUSY cycle -> release, timeout stays 0.
- Reset mid-grant: gnt0=1, rst driven low between edges -> gnt0 and busy fall immediately; after release, req1 and req0 both high -> gnt0 first (owner reset to 3).

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the four-master round-robin bus arbiter.
package bus_arbiter_pkg;
  localparam int NUM_MST     = 4;
  localparam int TIMEOUT_DEF = 16;

  // Signal level constants shared with the switch fabric.
  localparam logic LVL_ACT_HI = 1'b1;
  localparam logic LVL_ACT_LO = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after the pointer, wrapping mod 4.
module rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_win,
  output logic       o_valid
);

  always_comb begin
    o_win   = i_ptr;
    o_valid = 1'b0;
    // Offset 4 wraps to the pointer itself, so the last grantee is searched last.
    for (int k = 1; k <= NUM_MST; k++) begin
      if (!o_valid && i_req[i_ptr + 2'(k)] == LVL_ACT_HI) begin
        o_win   = i_ptr + 2'(k);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin arbiter: holds a grant until ack, request drop, or timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  input  logic       ack,
  output logic       gnt0,
  output logic       gnt1,
  output logic       gnt2,
  output logic       gnt3,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [3:0]       w_req;
  logic [1:0]       w_win;
  logic             w_valid;

  state_t           r_state;
  logic [3:0]       r_gnt;
  logic [1:0]       r_owner;
  logic             r_busy;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  assign w_req = {req3, req2, req1, req0};

  rr_pick u_pick (
    .i_req   (w_req),
    .i_ptr   (r_owner),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  // owner doubles as the round-robin pointer; reset to 3 so master 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_owner   <= 2'd3;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gnt   <= 4'b0001 << w_win;
            r_owner <= w_win;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (ack || w_req[r_owner] != LVL_ACT_HI) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0    = r_gnt[0];
  assign gnt1    = r_gnt[1];
  assign gnt2    = r_gnt[2];
  assign gnt3    = r_gnt[3];
  assign owner   = r_owner;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: grant latency, round-robin order, timeout, abandon, reset.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, req2 = 1'b0, req3 = 1'b0;
  logic       ack = 1'b0;
  logic       gnt0, gnt1, gnt2, gnt3;
  logic [1:0] owner;
  logic       busy, timeout;

  int total = 0;
  int bad   = 0;

  // Observation vector: {gnt3..gnt0, owner, busy, timeout}
  logic [8:0] obs;
  logic [8:0] exp;
  assign obs = {gnt3, gnt2, gnt1, gnt0, owner, busy, timeout};

  bus_arbiter #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req0),
    .req1    (req1),
    .req2    (req2),
    .req3    (req3),
    .ack     (ack),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .gnt2    (gnt2),
    .gnt3    (gnt3),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    {req3, req2, req1, req0} = 4'b0;
    ack = 1'b0;
    rst = 1'b0;
    #2;
    exp = {4'b0000, 2'd3, 2'b00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_state got=%b want=%b", obs, exp); end
    rst = 1'b1;
    tick();
    exp = {4'b0000, 2'd3, 2'b00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_idle got=%b want=%b", obs, exp); end
  endtask

  task automatic test_single;
    do_reset();
    tick();
    req2 = 1'b1;
    tick();
    exp = {4'b0100, 2'd2, 2'b10};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL single_grant got=%b want=%b", obs, exp); end
    ack = 1'b1;
    tick();
    exp = {4'b0000, 2'd2, 2'b00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL single_ack got=%b want=%b", obs, exp); end
    ack = 1'b0;
    req2 = 1'b0;
    tick();
    exp = {4'b0000, 2'd2, 2'b00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL single_stay_idle got=%b want=%b", obs, exp); end
  endtask

  task automatic test_ack_in_idle;
    do_reset();
    ack = 1'b1;
    req2 = 1'b1;
    tick();
    exp = {4'b0100, 2'd2, 2'b10};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL idle_ack_ignored got=%b want=%b", obs, exp); end
    tick();
    exp = {4'b0000, 2'd2, 2'b00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL idle_ack_release got=%b want=%b", obs, exp); end
    ack = 1'b0;
    req2 = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    {req3, req2, req1, req0} = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = {4'(1 << order[i]), 2'(order[i]), 2'b10};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL rr_grant_%0d got=%b want=%b", i, obs, exp); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      exp = {4'b0000, 2'(order[i]), 2'b00};
      total++;
      if (obs !== exp) begin bad++; $display("FAIL rr_gap_%0d got=%b want=%b", i, obs, exp); end
    end
    {req3, req2, req1, req0} = 4'b0;
    tick();
  endtask

  task automatic test_timeout;
    do_reset();
    req1 = 1'b1;
    tick();
    exp = {4'b0010, 2'd1, 2'b10};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL to_grant got=%b want=%b", obs, exp); end
    for (int i = 1; i < 16; i++) begin
      tick();
      total++;
      if (obs !== exp) begin bad++; $display("FAIL to_hold_%0d got=%b want=%b", i, obs, exp); end
    end
    tick();
    exp = {4'b0000, 2'd1, 2'b01};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL to_pulse got=%b want=%b", obs, exp); end
    tick();
    exp = {4'b0010, 2'd1, 2'b10};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL to_regrant got=%b want=%b", obs, exp); end
    req1 = 1'b0;
    tick();
    exp = {4'b0000, 2'd1, 2'b00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL to_drop got=%b want=%b", obs, exp); end
  endtask

  task automatic test_abandon;
    do_reset();
    req3 = 1'b1;
    tick();
    exp = {4'b1000, 2'd3, 2'b10};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL ab_grant got=%b want=%b", obs, exp); end
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (obs !== exp) begin bad++; $display("FAIL ab_hold got=%b want=%b", obs, exp); end
    req3 = 1'b0;
    tick();
    exp = {4'b0000, 2'd3, 2'b00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL ab_release got=%b want=%b", obs, exp); end
    tick();
    total++;
    if (obs !== exp) begin bad++; $display("FAIL ab_no_pulse got=%b want=%b", obs, exp); end
  endtask

  task automatic test_collision;
    do_reset();
    req0 = 1'b1;
    tick();
    exp = {4'b0001, 2'd0, 2'b10};
    for (int i = 1; i < 16; i++) tick();
    total++;
    if (obs !== exp) begin bad++; $display("FAIL col_hold16 got=%b want=%b", obs, exp); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req0 = 1'b0;
    exp = {4'b0000, 2'd0, 2'b00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL col_release got=%b want=%b", obs, exp); end
    tick();
    total++;
    if (obs !== exp) begin bad++; $display("FAIL col_no_pulse got=%b want=%b", obs, exp); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    req0 = 1'b1;
    tick();
    tick();
    exp = {4'b0001, 2'd0, 2'b10};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rm_grant got=%b want=%b", obs, exp); end
    #2;
    rst = 1'b0;
    #1;
    exp = {4'b0000, 2'd3, 2'b00};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rm_async_drop got=%b want=%b", obs, exp); end
    req1 = 1'b1;
    req0 = 1'b1;
    rst = 1'b1;
    tick();
    exp = {4'b0001, 2'd0, 2'b10};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rm_prio0 got=%b want=%b", obs, exp); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    exp = {4'b0010, 2'd1, 2'b10};
    total++;
    if (obs !== exp) begin bad++; $display("FAIL rm_next1 got=%b want=%b", obs, exp); end
    {req3, req2, req1, req0} = 4'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_ack_in_idle();
    test_round_robin();
    test_timeout();
    test_abandon();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
